// File: rtl/alu_sequencer.sv
// alu_sequencer: sequences commands onto an external 16-bit ALU; MUL (shift-add) only when ALU_SEQ_MUL_EN is defined
module alu_sequencer #(
  parameter int MulBits = 16
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        InValid,
  output logic        InReady,
  input  logic [2:0]  Opcode,
  input  logic [15:0] OpA,
  input  logic [15:0] OpB,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [15:0] Result,
  output logic        Zero,
  output logic        Overflow,
  output logic        CarryOut,
  output logic        Error,
  output logic [15:0] AluA,
  output logic [15:0] AluB,
  output logic [2:0]  AluOperation,
  output logic        AluBNegate,
  input  logic [15:0] AluResult,
  input  logic        AluZero,
  input  logic        AluOverflow,
  input  logic        AluCarryOut
);
  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
`ifdef ALU_SEQ_MUL_EN
    , MUL
`endif
  } state_t;
  state_t state, state_n;
  logic [2:0] op;
  logic [15:0] a, b;
  logic accept, illegal;
  assign accept = InValid && state == IDLE;
`ifdef ALU_SEQ_MUL_EN
  logic [15:0] acc, mcand, mplier;
  logic [4:0] cnt;
  logic sticky, last;
  assign last = cnt == 5'(MulBits - 1);
  assign illegal = Opcode[2] & Opcode[1];
`else
  assign illegal = Opcode[2] & (Opcode[1] | Opcode[0]);
`endif
  // state register, latched command and registered result/flags
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      op <= '0;
      a <= '0;
      b <= '0;
      {Result, Zero, Overflow, CarryOut, Error} <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        op <= Opcode;
        a <= OpA;
        b <= OpB;
        if (illegal) {Result, Zero, Overflow, CarryOut, Error} <= {16'h0, 4'b0001};
      end
      if (state == EXEC) {Result, Zero, Overflow, CarryOut, Error} <= {AluResult, AluZero, AluOverflow, AluCarryOut, 1'b0};
`ifdef ALU_SEQ_MUL_EN
      if (state == MUL && last)
        {Result, Zero, Overflow, CarryOut, Error} <= {AluResult, AluResult == 16'h0, 1'b0, sticky | AluCarryOut, 1'b0};
`endif
    end
  end
`ifdef ALU_SEQ_MUL_EN
  // shift-add multiplier datapath: one ALU add per multiplier bit
  always_ff @(posedge Clock) begin
    if (Reset) begin
      {acc, mcand, mplier, cnt, sticky} <= '0;
    end else if (accept) begin
      {acc, mcand, mplier, cnt, sticky} <= {16'h0, OpA, OpB, 5'd0, 1'b0};
    end else if (state == MUL) begin
      acc <= AluResult;
      sticky <= sticky | AluCarryOut;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt + 5'd1;
    end
  end
`endif
  // next state and ALU drive; reset forces the idle drive immediately
  always_comb begin
    state_n = state;
    AluA = '0;
    AluB = '0;
    AluOperation = '0;
    AluBNegate = 1'b0;
    case (state)
      IDLE: begin
`ifdef ALU_SEQ_MUL_EN
        if (InValid) state_n = illegal ? DONE : Opcode == 3'b101 ? MUL : EXEC;
`else
        if (InValid) state_n = illegal ? DONE : EXEC;
`endif
      end
      EXEC: begin
        state_n = DONE;
        AluA = a;
        AluB = b;
        AluOperation = op == 3'b100 ? 3'b011 : op == 3'b011 ? 3'b010 : op;
        AluBNegate = op == 3'b011 || op == 3'b100;
      end
`ifdef ALU_SEQ_MUL_EN
      MUL: begin
        state_n = last ? DONE : MUL;
        AluA = acc;
        AluB = mplier[0] ? mcand : '0;
        AluOperation = 3'b010;
      end
`endif
      DONE: state_n = OutReady ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
    if (Reset) begin
      AluA = '0;
      AluB = '0;
      AluOperation = '0;
      AluBNegate = 1'b0;
    end
  end
  assign InReady = state == IDLE || Reset;
  assign OutValid = state == DONE && !Reset;
endmodule
